cs_out_buffer: RTL and testbench
================================

# cs_out_buffer

Downstream stage of the CS filter. It consumes the 10-bit `Y` stream that CS produces once per input sample, discards the warm-up outputs produced before CS's 9-sample window is full, and queues valid results in a small FIFO. The queued results are delivered to the consumer over a valid/ready handshake. The block also flags any result lost to overflow.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, 2..64.
- `WARMUP`, 8: number of leading input strobes discarded after reset.
- `LW`, `$clog2(DEPTH)+1`: width of `level`; derived, not overridden.
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-low reset; sampled on the rising edge of `clk`.
- `y_in` input 10: CS result (`Y`).
- `in_en` input 1: strobe; `y_in` belongs to a new sample this cycle.
- `out_ready` input 1: consumer accepts `out_data` this cycle.
- `out_data` output 10: FIFO head; reset value 0.
- `out_valid` output 1: FIFO non-empty; reset value 0.
- `level` output LW: current entry count, 0..DEPTH; reset value 0.
- `warm` output 1: warm-up complete; reset value 0.
- `ovf` output 1: sticky overflow flag; reset value 0.
- `checksum` output 16: only present with the macro defined (see Configuration); reset value 0.

## Operation
**Warm-up counter**
- Counter `wcnt` is 0..WARMUP and saturates at WARMUP.
- Each rising edge with `in_en=1` and `wcnt<WARMUP`: `wcnt` increments and `y_in` is dropped.
- `warm = (wcnt==WARMUP)`.
- With `WARMUP=0`, `warm` is 1 from the first cycle after reset.

**Push**
- Push condition: `in_en & warm`.
- Data pushed: `y_in` as sampled on that edge.

**Pop**
- Pop condition: `out_valid & out_ready`.
- `out_valid=1` iff `level>0`.
- `out_data` always shows the entry at the read pointer. It is first-word-fall-through; no extra read latency.
- Behaviour on `out_data` when `level==0` is don't-care, but it must not be X after reset.

**Boundary conditions**
- Full, push, no pop: data dropped; `ovf` set; `level` stays at DEPTH.
- Full, push and pop on the same edge: both take effect; `level` stays at DEPTH; `ovf` is not set.
- Empty, push: accepted; a pop cannot occur because `out_valid=0`.
- Push and pop on the same edge, non-empty: `level` unchanged.
- Pointer wrap: read and write pointers are `log2(DEPTH)` bits and wrap modulo DEPTH; full and empty are resolved from `level`.
- `ovf` is cleared only by reset.

**Reset**
- `reset=0` on any rising edge clears `wcnt`, both pointers, `level`, `ovf`, `checksum` and `out_data`.
- This holds mid-stream, including mid-warm-up.
- FIFO storage contents are not cleared.

## Timing
- Push on edge N: `out_valid` and the new `level` are visible after edge N, so the result is available to the consumer in cycle N+1.
- Pop on edge N: the next head appears after edge N.
- The first real result is the (WARMUP+1)-th `in_en` strobe after reset.
- `in_en` may be asserted every cycle; sustained throughput is one push and one pop per cycle.
- The reset input has no asynchronous path; outputs change only after `clk` edges.

## Configuration
- Macro `CS_OUTBUF_CHECKSUM_EN`.
- **Defined:** port `checksum[15:0]` exists.
  - On every pop: `checksum <= {checksum[14:0],checksum[15]} + {6'b0,out_data}`, i.e. rotate-left-1 then add, modulo 2^16.
  - Reset value 0.
- **Undefined:** the port and its logic are absent; all other behaviour is identical.

## Test plan
1. **Warm-up discard.** Reset, then 8 strobes with `y_in=0x3FF`, then 1 strobe with `y_in=0x155`, `out_ready=0`.
   - Required: `warm` rises after the 8th strobe, `level=1`, `out_data=0x155`, no `0x3FF` ever queued.
2. **Overflow.** After warm-up, 9 strobes with values 1..9, `out_ready=0`.
   - Required: `level=8`, `ovf=1`, pops return 1..8 in order, value 9 is lost.
3. **Full push+pop.** FIFO full with 1..8; one edge with `in_en=1`, `y_in=0x0AA`, `out_ready=1`.
   - Required: `level` stays 8, `ovf=0`, subsequent pops return 2..8 then `0x0AA`.
4. **Streaming wrap.** Strobe every cycle with `y_in` = 0..99, `out_ready=1` throughout.
   - Required: output sequence 0..99, each one cycle after its push, `level` never exceeds 1.
5. **Reset mid-operation.** With `level=5` and `ovf=1`, drive `reset=0` for one edge.
   - Required: `level=0`, `out_valid=0`, `ovf=0`, `warm=0`; the next 8 strobes are discarded again.
6. **Checksum (`CS_OUTBUF_CHECKSUM_EN` defined).** Pop `0x001`, `0x002`, `0x003`.
   - Required: `checksum` = `0x0001`, then `0x0004`, then `0x000B`.

Source files
------------

// File: rtl/cs_out_buffer.sv
// ============================================================================
// Module   : cs_out_buffer
// Purpose  : Output stage of the CS filter.  It drops the warm-up results and
//            queues the valid ones in a first-word-fall-through FIFO with a
//            valid/ready output and a sticky overflow flag.
// Options  : CS_OUTBUF_CHECKSUM_EN adds a rotate-and-add checksum of popped data.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cs_out_buffer #(
    parameter int DEPTH  = 8,
    parameter int WARMUP = 8,
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [9:0]    y_in,
    input  logic          in_en,
    input  logic          out_ready,
    output logic [9:0]    out_data,
    output logic          out_valid,
    output logic [LW-1:0] level,
    output logic          warm,
`ifdef CS_OUTBUF_CHECKSUM_EN
    output logic [15:0]   checksum,
`endif
    output logic          ovf
);

    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WW   = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;

    localparam logic [WW-1:0] c_WARM_LIM = WW'(WARMUP);
    localparam logic [LW-1:0] c_FULL_LVL = LW'(DEPTH);

    logic [9:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [LW-1:0] r_level;
    logic [WW-1:0] r_wcnt;
    logic [9:0]    r_out_data;
    logic          r_ovf;

    logic          w_warm;
    logic          w_full;
    logic          w_push;
    logic          w_push_ok;
    logic          w_pop;
    logic [AW-1:0] w_rptr_nxt;
    logic [LW-1:0] w_level_nxt;
    logic [9:0]    w_head_nxt;

    assign w_warm    = (r_wcnt == c_WARM_LIM);
    assign w_full    = (r_level == c_FULL_LVL);
    assign w_pop     = (r_level != '0) & out_ready;
    assign w_push    = in_en & w_warm;
    // A push into a full FIFO only lands when the same edge frees a slot.
    assign w_push_ok = w_push & (~w_full | w_pop);

    always_comb begin
        w_rptr_nxt  = r_rptr;
        w_level_nxt = r_level;
        if (w_pop) begin
            w_rptr_nxt = r_rptr + AW'(1);
        end
        unique case ({w_push_ok, w_pop})
            2'b10:   w_level_nxt = r_level + LW'(1);
            2'b01:   w_level_nxt = r_level - LW'(1);
            default: w_level_nxt = r_level;
        endcase
    end

    // The head is registered so it is defined after reset even though the
    // storage is not cleared; a word written this edge is forwarded directly.
    always_comb begin
        w_head_nxt = r_mem[w_rptr_nxt];
        if (w_push_ok && (r_wptr == w_rptr_nxt)) begin
            w_head_nxt = y_in;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= y_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_wcnt     <= '0;
            r_out_data <= '0;
            r_ovf      <= 1'b0;
        end else begin
            if (in_en && !w_warm) begin
                r_wcnt <= r_wcnt + WW'(1);
            end
            if (w_push_ok) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_push && !w_push_ok) begin
                r_ovf <= 1'b1;
            end
            r_rptr  <= w_rptr_nxt;
            r_level <= w_level_nxt;
            if (w_level_nxt != '0) begin
                r_out_data <= w_head_nxt;
            end
        end
    end

`ifdef CS_OUTBUF_CHECKSUM_EN
    logic [15:0] r_checksum;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_checksum <= '0;
        end else if (w_pop) begin
            r_checksum <= {r_checksum[14:0], r_checksum[15]} + {6'b0, r_out_data};
        end
    end

    assign checksum = r_checksum;
`endif

    assign out_data  = r_out_data;
    assign out_valid = (r_level != '0);
    assign level     = r_level;
    assign warm      = w_warm;
    assign ovf       = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_cs_out_buffer.sv
// ============================================================================
// Module   : tb_cs_out_buffer
// Purpose  : Directed self-checking bench for cs_out_buffer (DEPTH=8,
//            WARMUP=8); the checksum steps run when CS_OUTBUF_CHECKSUM_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cs_out_buffer;

    logic        clk;
    logic        reset;
    logic [9:0]  y_in;
    logic        in_en;
    logic        out_ready;
    logic [9:0]  out_data;
    logic        out_valid;
    logic [3:0]  level;
    logic        warm;
    logic        ovf;
`ifdef CS_OUTBUF_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    int errors = 0;
    int checks = 0;

    cs_out_buffer #(.DEPTH(8), .WARMUP(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .y_in      (y_in),
        .in_en     (in_en),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .level     (level),
        .warm      (warm),
`ifdef CS_OUTBUF_CHECKSUM_EN
        .checksum  (checksum),
`endif
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, take the edge, then settle 1 ns past it.
    task automatic cyc(input logic en, input logic [9:0] y, input logic rdy);
        in_en     = en;
        y_in      = y;
        out_ready = rdy;
        @(posedge clk);
        #1;
        in_en     = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b0; in_en = 1'b0; y_in = '0; out_ready = 1'b0;
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("rst_level", level, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_warm", warm, 0);
        chk("rst_ovf", ovf, 0);
`ifdef CS_OUTBUF_CHECKSUM_EN
        chk("rst_checksum", checksum, 0);
`endif
        reset = 1'b1;

        // Warm-up discard
        for (int i = 1; i <= 8; i++) begin
            cyc(1, 10'h3FF, 0);
            chk("wu_level", level, 0);
            chk("wu_warm", warm, (i == 8) ? 1 : 0);
        end
        cyc(1, 10'h155, 0);
        chk("wu_first_level", level, 1);
        chk("wu_first_valid", out_valid, 1);
        chk("wu_first_data", out_data, 10'h155);
        cyc(0, 0, 1);
        chk("wu_pop_level", level, 0);
        chk("wu_pop_valid", out_valid, 0);

        // Overflow: 9 pushes into 8 entries
        for (int i = 1; i <= 9; i++) begin
            cyc(1, 10'(i), 0);
            chk("ov_level", level, (i < 8) ? i : 8);
            chk("ov_flag", ovf, (i == 9) ? 1 : 0);
        end
        for (int i = 1; i <= 8; i++) begin
            chk("ov_pop_data", out_data, i);
            chk("ov_pop_valid", out_valid, 1);
            cyc(0, 0, 1);
        end
        chk("ov_drain_level", level, 0);
        chk("ov_drain_valid", out_valid, 0);
        chk("ov_sticky", ovf, 1);

        // Reset mid-operation with level=5, ovf=1
        for (int i = 10; i <= 14; i++) cyc(1, 10'(i), 0);
        chk("mr_pre_level", level, 5);
        reset = 1'b0;
        cyc(0, 0, 0);
        reset = 1'b1;
        chk("mr_level", level, 0);
        chk("mr_valid", out_valid, 0);
        chk("mr_ovf", ovf, 0);
        chk("mr_warm", warm, 0);
        for (int i = 1; i <= 8; i++) begin
            cyc(1, 10'h3FF, 0);
            chk("mr_wu_level", level, 0);
        end
        chk("mr_warm_again", warm, 1);

        // Full push+pop on the same edge
        for (int i = 1; i <= 8; i++) cyc(1, 10'(i), 0);
        chk("fp_full_level", level, 8);
        cyc(1, 10'h0AA, 1);
        chk("fp_level", level, 8);
        chk("fp_ovf", ovf, 0);
        for (int i = 2; i <= 9; i++) begin
            chk("fp_pop_data", out_data, (i == 9) ? 10'h0AA : 10'(i));
            cyc(0, 0, 1);
        end
        chk("fp_drain_level", level, 0);

        // Streaming with pointer wrap
        for (int i = 0; i < 100; i++) begin
            cyc(1, 10'(i), 1);
            chk("st_level", level, 1);
            chk("st_data", out_data, i);
        end
        cyc(0, 0, 1);
        chk("st_drain_level", level, 0);
        chk("st_ovf", ovf, 0);

`ifdef CS_OUTBUF_CHECKSUM_EN
        reset = 1'b0;
        cyc(0, 0, 0);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) cyc(1, 10'h3FF, 0);
        for (int i = 1; i <= 3; i++) cyc(1, 10'(i), 0);
        chk("ck_start", checksum, 16'h0000);
        cyc(0, 0, 1);
        chk("ck_pop1", checksum, 16'h0001);
        cyc(0, 0, 1);
        chk("ck_pop2", checksum, 16'h0004);
        cyc(0, 0, 1);
        chk("ck_pop3", checksum, 16'h000B);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
